// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: turns a valid/ready request into one APB
// SETUP/ACCESS transfer and returns read data, slave error and timeout status.
`ifndef CFG_APB_DATA_WIDTH
`define CFG_APB_DATA_WIDTH 32
`endif

module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = `CFG_APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      apb_pclk,
    input  logic                      apb_presetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      apb_psel,
    output logic                      apb_penable,
    output logic                      apb_pwrite,
    output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
    input  logic                      apb_pready,
    input  logic                      apb_pslverr,
    input  logic [APB_DATA_WIDTH-1:0] apb_prdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic timeout_hit;

    // The abort fires on the edge that would take the counter to TIMEOUT_CYCLES.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

    always_ff @(posedge apb_pclk or negedge apb_presetn) begin
        if (!apb_presetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (apb_pready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        rsp_valid   = (state == RESP);
        apb_psel    = (state == SETUP) || (state == ACCESS);
        apb_penable = (state == ACCESS);
    end

    // APB address/data persist after the transfer; response fields are only
    // written on the completing ACCESS edge, so they hold through RESP.
    always_ff @(posedge apb_pclk or negedge apb_presetn) begin
        if (!apb_presetn) begin
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        apb_pwrite <= req_write;
                        apb_paddr  <= req_addr;
                        apb_pwdata <= req_write ? req_wdata : '0;
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (apb_pready) begin
                        rsp_err     <= apb_pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= apb_pwrite ? '0 : apb_prdata;
                    end else begin
                        if (!(&wait_cnt)) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (timeout_hit) begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: table-driven transfers with a
// response scoreboard, plus a hand-written reset-during-ACCESS sequence.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          apb_pclk = 1'b0;
    logic          apb_presetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          apb_psel;
    logic          apb_penable;
    logic          apb_pwrite;
    logic [AW-1:0] apb_paddr;
    logic [DW-1:0] apb_pwdata;
    logic          apb_pready = 1'b0;
    logic          apb_pslverr = 1'b0;
    logic [DW-1:0] apb_prdata = '0;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .apb_pclk(apb_pclk),
        .apb_presetn(apb_presetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .apb_psel(apb_psel),
        .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr),
        .apb_pwdata(apb_pwdata),
        .apb_pready(apb_pready),
        .apb_pslverr(apb_pslverr),
        .apb_prdata(apb_prdata)
    );

    always #5 apb_pclk = ~apb_pclk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            wait_cycles;
        int            bp_cycles;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_timeout;
        int            exp_access;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          timeout;
    } rsp_t;

    rsp_t sb_q[$];
    vec_t vecs[8];
    int checks = 0;
    int failures = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drives the request at a falling edge and checks the SETUP cycle that follows.
    task automatic applyStimulus(input vec_t v);
        rsp_t e;
        check1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        e.timeout = v.exp_timeout;
        sb_q.push_back(e);
        @(posedge apb_pclk);
        @(negedge apb_pclk);
        req_valid = 1'b0;
        req_addr  = ~req_addr;
        req_wdata = ~req_wdata;
        check1("setup_psel", apb_psel, 1'b1);
        check1("setup_penable", apb_penable, 1'b0);
        check1("setup_req_ready", req_ready, 1'b0);
        check32("setup_paddr", apb_paddr, v.addr);
        check1("setup_pwrite", apb_pwrite, v.write);
        check32("setup_pwdata", apb_pwdata, v.write ? v.wdata : 32'h0);
    endtask

    // Plays the responder through ACCESS, then checks and retires the response.
    task automatic checkOutput(input vec_t v);
        int   access = 0;
        int   edges = 0;
        rsp_t e;
        @(posedge apb_pclk);
        edges++;
        @(negedge apb_pclk);
        while (apb_penable && access < 20) begin
            access++;
            check1("access_psel", apb_psel, 1'b1);
            check32("access_paddr", apb_paddr, v.addr);
            apb_pready  = (access == v.wait_cycles + 1);
            apb_pslverr = v.slverr;
            apb_prdata  = v.prdata;
            @(posedge apb_pclk);
            edges++;
            @(negedge apb_pclk);
        end
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_prdata  = $urandom;
        check32("access_cycles", access, v.exp_access);
        if (!rsp_valid) begin
            check1("rsp_valid_bound", rsp_valid, 1'b1);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            apb_presetn = 1'b0;
            @(negedge apb_pclk);
            apb_presetn = 1'b1;
            return;
        end
        check32("rsp_latency", 1 + edges, 2 + v.exp_access);
        check1("resp_psel", apb_psel, 1'b0);
        check1("resp_penable", apb_penable, 1'b0);
        check1("resp_req_ready", req_ready, 1'b0);
        check32("resp_paddr_kept", apb_paddr, v.addr);
        if (sb_q.size() == 0) begin
            check1("scoreboard_empty", 1'b1, 1'b0);
            return;
        end
        e = sb_q.pop_front();
        check32("rsp_rdata", rsp_rdata, e.rdata);
        check1("rsp_err", rsp_err, e.err);
        check1("rsp_timeout", rsp_timeout, e.timeout);
        for (int i = 0; i < v.bp_cycles; i++) begin
            @(posedge apb_pclk);
            @(negedge apb_pclk);
            check1("bp_rsp_valid", rsp_valid, 1'b1);
            check32("bp_rsp_rdata", rsp_rdata, e.rdata);
            check1("bp_rsp_err", rsp_err, e.err);
            check1("bp_psel", apb_psel, 1'b0);
            check1("bp_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge apb_pclk);
        @(negedge apb_pclk);
        rsp_ready = 1'b0;
        check1("done_req_ready", req_ready, 1'b1);
        check1("done_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h1000_0000, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h2000_0004, 32'hFFFF_FFFF, 32'h0000_003C, 1'b0, 1, 0, 32'h0000_003C, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b0, 32'h3000_0008, 32'h0, 32'h0000_0BAD, 1'b1, 0, 0, 32'h0000_0BAD, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h4000_000C, 32'h0, 32'h0000_1234, 1'b0, 99, 0, 32'h0, 1'b1, 1'b1, 4};
        vecs[4] = '{1'b1, 32'h4000_0010, 32'h1357_9BDF, 32'h0, 1'b0, 3, 0, 32'h0, 1'b0, 1'b0, 4};
        vecs[5] = '{1'b1, 32'h5000_0014, 32'h0F0F_0F0F, 32'h0, 1'b1, 2, 0, 32'h0, 1'b1, 1'b0, 3};
        vecs[6] = '{1'b0, 32'h6000_0018, 32'h0, 32'h5555_AAAA, 1'b0, 0, 5, 32'h5555_AAAA, 1'b0, 1'b0, 1};
        vecs[7] = '{1'b1, 32'h7000_001C, 32'h2468_ACE0, 32'h0, 1'b0, 99, 2, 32'h0, 1'b1, 1'b1, 4};

        #3;
        check1("rst_psel", apb_psel, 1'b0);
        check1("rst_penable", apb_penable, 1'b0);
        check1("rst_pwrite", apb_pwrite, 1'b0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        check1("rst_rsp_timeout", rsp_timeout, 1'b0);
        check32("rst_paddr", apb_paddr, 32'h0);
        check32("rst_pwdata", apb_pwdata, 32'h0);
        check32("rst_rsp_rdata", rsp_rdata, 32'h0);
        check1("rst_req_ready", req_ready, 1'b1);
        @(negedge apb_pclk);
        @(negedge apb_pclk);
        apb_presetn = 1'b1;
        @(negedge apb_pclk);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d addr=%h write=%0b", i, vecs[i].addr, vecs[i].write);
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Reset asserted mid-ACCESS: the transfer is dropped with no response.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'h0;
        @(posedge apb_pclk);
        @(negedge apb_pclk);
        req_valid = 1'b0;
        @(posedge apb_pclk);
        @(negedge apb_pclk);
        check1("pre_rst_penable", apb_penable, 1'b1);
        #2 apb_presetn = 1'b0;
        #1;
        check1("mid_rst_psel", apb_psel, 1'b0);
        check1("mid_rst_penable", apb_penable, 1'b0);
        @(negedge apb_pclk);
        apb_presetn = 1'b1;
        check1("post_rst_req_ready", req_ready, 1'b1);
        check1("post_rst_rsp_valid", rsp_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge apb_pclk);
            check1("post_rst_idle_valid", rsp_valid, 1'b0);
            check1("post_rst_idle_psel", apb_psel, 1'b0);
        end
        applyStimulus(vecs[1]);
        checkOutput(vecs[1]);

        check32("scoreboard_drained", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
